// File: rtl/bus_initiator.sv
// bus_initiator: host-to-responder bridge driving a multiplexed address/data bus with a high-byte cache
module bus_initiator #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        wb_clk_i,
   input  logic        rst,
   input  logic        cfg_enable,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        bus_en,
   output logic        le_lo_act,
   output logic        le_hi_act,
   output logic        WEb_raw,
   output logic [7:0]  bus_out,
   input  logic [7:0]  bus_in
);
   typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, WRITE, WAIT, SAMPLE, RESP} state_t;
   localparam logic [3:0] WAIT_LD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   state_t      state_q;
   logic        we_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  hi_q;
   logic        hi_vld_q;
   logic [3:0]  cnt_q;
   logic [7:0]  rdata_q;
   logic        bus_en_q;
   // Sequencer: request capture, high-byte cache, wait countdown and read capture
   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 8'h00;
         hi_q     <= 8'h00;
         hi_vld_q <= 1'b0;
         cnt_q    <= 4'd0;
         rdata_q  <= 8'h00;
         bus_en_q <= 1'b0;
      end else begin
         bus_en_q <= cfg_enable;
         if (!cfg_enable) begin
            state_q  <= IDLE;
            hi_vld_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  state_q <= (hi_vld_q && req_addr[15:8] == hi_q) ? ADDR_LO : ADDR_HI;
               end
               ADDR_HI: begin
                  hi_q     <= addr_q[15:8];
                  hi_vld_q <= 1'b1;
                  state_q  <= ADDR_LO;
               end
               ADDR_LO: begin
                  cnt_q   <= WAIT_LD;
                  state_q <= we_q ? WRITE : (WAIT_STATES > 0) ? WAIT : SAMPLE;
               end
               WAIT: begin
                  cnt_q   <= (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                  state_q <= (cnt_q == 4'd0) ? SAMPLE : WAIT;
               end
               SAMPLE: begin
                  rdata_q <= bus_in;
                  state_q <= RESP;
               end
               WRITE:   state_q <= RESP;
               RESP:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   // Moore decode of the bus strobes; ready is held off while reset is asserted
   always_comb begin
      req_ready = state_q == IDLE && cfg_enable && !rst;
      rsp_valid = state_q == RESP;
      le_hi_act = state_q == ADDR_HI;
      le_lo_act = state_q == ADDR_LO;
      WEb_raw   = state_q != WRITE;
      bus_out   = (state_q == ADDR_HI) ? addr_q[15:8] :
                  (state_q == ADDR_LO) ? addr_q[7:0]  :
                  (state_q == WRITE)   ? wdata_q      : 8'h00;
   end
   assign rsp_rdata = rdata_q;
   assign bus_en    = bus_en_q;
endmodule
